// File: rtl/mem_vec_stage_pkg.sv
// Shared sizes, operation/state encodings and the lane-slice helper for the
// vector memory stage.
package mem_stage_pkg;

   localparam int ADDR_W     = 21;
   localparam int LANE_W     = 24;
   localparam int LANES      = 8;
   localparam int VEC_W      = LANES * LANE_W;
   localparam int LANE_IDX_W = $clog2(LANES);

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PASS = 2'd1,
      OP_VLD  = 2'd2,
      OP_VST  = 2'd3
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      LDRAIN = 2'd2,
      STORE  = 2'd3
   } state_t;

   function automatic logic [LANE_W-1:0] lane_sel(input logic [VEC_W-1:0]      vec,
                                                   input logic [LANE_IDX_W-1:0] i);
      return vec[i*LANE_W +: LANE_W];
   endfunction

endpackage

// File: rtl/mem_vec_stage_if.sv
// Bundles the execute-side, data-memory and writeback signals of the stage.
// The stage itself uses the slave view; the surrounding pipeline uses master.
interface mem_vec_stage_if;
   import mem_stage_pkg::*;

   logic              valid_in;
   mem_op_t           op_in;
   logic [ADDR_W-1:0] addr_in;
   logic [VEC_W-1:0]  vec_in;
   logic              stall;

   logic [ADDR_W-1:0] mem_addr;
   logic [LANE_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [LANE_W-1:0] mem_rdata;

   logic              wb_valid;
   logic              wb_is_vec;
   logic [ADDR_W-1:0] wb_scalar;
   logic [VEC_W-1:0]  wb_vec;

   modport slave (
      input  valid_in, op_in, addr_in, vec_in, mem_rdata,
      output stall, mem_addr, mem_wdata, mem_we, mem_re,
             wb_valid, wb_is_vec, wb_scalar, wb_vec
   );

   modport master (
      output valid_in, op_in, addr_in, vec_in, mem_rdata,
      input  stall, mem_addr, mem_wdata, mem_we, mem_re,
             wb_valid, wb_is_vec, wb_scalar, wb_vec
   );

endinterface

// File: rtl/mem_vec_stage_lane_seq.sv
// Lane counter plus base+lane word-address generator, shared by the vector
// load and store sequences. Addresses wrap modulo 2^ADDR_W.
module vec_lane_seq
   import mem_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  en_i,
   input  logic [ADDR_W-1:0]     base_i,
   output logic [LANE_IDX_W-1:0] lane_o,
   output logic [ADDR_W-1:0]     addr_o,
   output logic                  last_o
);

   logic [LANE_IDX_W-1:0] lane_q, lane_d;
   logic [ADDR_W-1:0]     base_q, base_d;

   // NOTE: every output of a combinational block gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      lane_d = lane_q;
      base_d = base_q;
      if (start_i) begin
         lane_d = '0;
         base_d = base_i;
      end else if (en_i) begin
         lane_d = lane_q + LANE_IDX_W'(1);
      end
   end

   // NOTE: clocked state is updated with non-blocking assignments so every
   // register samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q <= '0;
         base_q <= '0;
      end else begin
         lane_q <= lane_d;
         base_q <= base_d;
      end
   end

   assign lane_o = lane_q;
   assign addr_o = base_q + ADDR_W'(lane_q);
   assign last_o = (lane_q == LANE_IDX_W'(LANES - 1));

endmodule

// File: rtl/mem_vec_stage.sv
// Memory stage after execute: scalar pass-through, or a vector load/store
// serialised one lane per cycle over the single-lane data-memory port.
module mem_vec_stage
   import mem_stage_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   mem_vec_stage_if.slave bus
);

   state_t                state_q, state_d;
   logic                  accept;
   logic                  start_vec;
   logic                  seq_en;
   logic                  seq_last;
   logic [LANE_IDX_W-1:0] seq_lane;
   logic [ADDR_W-1:0]     seq_addr;

   logic [VEC_W-1:0]      vec_q;
   logic                  rd_pend_q;
   logic [LANE_IDX_W-1:0] rd_lane_q;
   logic                  wb_valid_q;
   logic                  wb_is_vec_q;
   logic [ADDR_W-1:0]     wb_scalar_q;

   assign accept    = (state_q == IDLE) && bus.valid_in && (bus.op_in != OP_NONE);
   assign start_vec = accept && ((bus.op_in == OP_VLD) || (bus.op_in == OP_VST));
   assign seq_en    = (state_q == LOAD) || (state_q == STORE);

   vec_lane_seq u_lane_seq (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_vec),
      .en_i    (seq_en),
      .base_i  (bus.addr_in),
      .lane_o  (seq_lane),
      .addr_o  (seq_addr),
      .last_o  (seq_last)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.stall     = (state_q != IDLE);
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state_q)
         IDLE: begin
            if (accept && (bus.op_in == OP_VLD))      state_d = LOAD;
            else if (accept && (bus.op_in == OP_VST)) state_d = STORE;
         end
         LOAD: begin
            bus.mem_re   = 1'b1;
            bus.mem_addr = seq_addr;
            if (seq_last) state_d = LDRAIN;
         end
         LDRAIN: begin
            state_d = IDLE;
         end
         STORE: begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = seq_addr;
            bus.mem_wdata = lane_sel(vec_q, seq_lane);
            if (seq_last) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Read data returns one cycle after its issue, so the issuing lane is
   // remembered for one cycle; LDRAIN exists to catch the final lane.
   // NOTE: the vector buffer is a register bank that is explicitly cleared on
   // reset, so a partially loaded vector never leaks into a later writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q       <= '0;
         rd_pend_q   <= 1'b0;
         rd_lane_q   <= '0;
         wb_valid_q  <= 1'b0;
         wb_is_vec_q <= 1'b0;
         wb_scalar_q <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         rd_pend_q  <= (state_q == LOAD);
         rd_lane_q  <= seq_lane;

         if (rd_pend_q) vec_q[rd_lane_q*LANE_W +: LANE_W] <= bus.mem_rdata;
         if (accept && (bus.op_in == OP_VST)) vec_q <= bus.vec_in;

         if (accept && (bus.op_in == OP_PASS)) begin
            wb_valid_q  <= 1'b1;
            wb_is_vec_q <= 1'b0;
            wb_scalar_q <= bus.addr_in;
         end
         if (state_q == LDRAIN) begin
            wb_valid_q  <= 1'b1;
            wb_is_vec_q <= 1'b1;
         end
      end
   end

   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_is_vec = wb_is_vec_q;
   assign bus.wb_scalar = wb_scalar_q;
   assign bus.wb_vec    = vec_q;

endmodule
